univ_shift_reg: RTL
===================

// Module: univ_shift_reg
// PURPOSE
//  Parametrised universal shift register: a WIDTH-bit bank of D flip-flops with
//  synchronous reset, clock enable and an 8-mode operation select (hold, shift,
//  rotate, arithmetic shift, parallel load, clear). Next-generation storage
//  primitive of the flipflop library; used for serialisers, delay lines, LFSR seeds.
// PARAMETERS
//  WIDTH      8     register width in bits, >= 2
//  RESET_VAL  '0    value loaded into q on rst (WIDTH bits)
//  CNT_W      8     width of shift_cnt (only with USR_SHIFT_CNT_EN)
// PORTS
//  clk        in   1      clock; all state updates on rising edge
//  rst        in   1      synchronous reset, active-high
//  en         in   1      clock enable; 0 = hold regardless of mode
//  mode       in   3      operation select (encodings in usr_pkg)
//  sin_l      in   1      serial in, enters q[0] on SHL
//  sin_r      in   1      serial in, enters q[WIDTH-1] on SHR
//  pdata      in   WIDTH  parallel load data
//  q          out  WIDTH  register contents
//  sout_l     out  1      q[WIDTH-1] (combinational from q)
//  sout_r     out  1      q[0] (combinational from q)
//  shift_cnt  out  CNT_W  shift-type ops performed (only with USR_SHIFT_CNT_EN)
// BEHAVIOUR
//  - One clock (clk); reset is synchronous and active-high (rst).
//  - rst=1 at edge: q<=RESET_VAL, shift_cnt<=0; overrides en and mode.
//  - rst=0,en=0: q and shift_cnt hold. rst=0,en=1: per mode, latency 1 clk:
//      000 HOLD  q<=q
//      001 SHL   q<={q[WIDTH-2:0],sin_l}
//      010 SHR   q<={sin_r,q[WIDTH-1:1]}
//      011 ROL   q<={q[WIDTH-2:0],q[WIDTH-1]}
//      100 ROR   q<={q[0],q[WIDTH-1:1]}
//      101 ASR   q<={q[WIDTH-1],q[WIDTH-1:1]} (sign preserved)
//      110 LOAD  q<=pdata
//      111 CLR   q<='0 (not RESET_VAL)
//  - sout_l/sout_r show pre-edge q; bit shifted out is visible on them before it is lost.
//  - mode is sampled only at the enabled edge; no internal state beyond q/shift_cnt.
//  - X/unknown mode bits never occur in the verified environment; no default trap.
// CONFIGURATION
//  USR_SHIFT_CNT_EN defined: shift_cnt port present; +1 on each enabled
//    SHL/SHR/ROL/ROR/ASR, saturates at 2**CNT_W-1; cleared by rst, LOAD, CLR;
//    held by HOLD or en=0.
//  Undefined: shift_cnt port and counter logic absent; q behaviour identical.
// STRUCTURE
//  - usr_pkg: typedef enum logic [2:0] usr_mode_e {HOLD,SHL,SHR,ROL,ROR,ASR,LOAD,CLR}
//    with the encodings above; shared by RTL and bench.
//  - Sub-module dff_en_srst: WIDTH-parametrised D register with enable and sync
//    reset to a parameter value; top computes next-state mux and instantiates one.
// TESTING  (WIDTH=8, RESET_VAL=8'hA5, CNT_W=4)
//  1 rst=1 one edge, any en/mode -> q=8'hA5, sout_l=1, sout_r=1, shift_cnt=0
//  2 LOAD pdata=8'h81, then SHL sin_l=0 x2 -> q=8'h02 then 8'h04; en=0 -> q holds 8'h04
//  3 LOAD 8'h81, ROR -> 8'hC0; ROL -> 8'h81; SHR sin_r=1 -> 8'hC0
//  4 LOAD 8'h90, ASR x3 -> 8'hC8, 8'hE4, 8'hF2; CLR -> 8'h00 (not A5)
//  5 rst=1 asserted with en=1,mode=LOAD,pdata=8'h3C -> q=8'hA5 (reset wins)
//  6 USR_SHIFT_CNT_EN: 20 enabled SHL -> shift_cnt=15 (saturated); LOAD -> 0

Source files
------------

// File: rtl/usr_pkg.sv
// Shared definitions for the universal shift register.
// usr_mode_e is the operation select encoding. RTL and bench both use it.
package usr_pkg;
  typedef enum logic [2:0] {
    HOLD = 3'b000,
    SHL  = 3'b001,
    SHR  = 3'b010,
    ROL  = 3'b011,
    ROR  = 3'b100,
    ASR  = 3'b101,
    LOAD = 3'b110,
    CLR  = 3'b111
  } usr_mode_e;

  // Ops that move bits and so advance the optional shift counter
  function automatic logic is_shift_op(input usr_mode_e m);
    return (m == SHL) || (m == SHR) || (m == ROL) || (m == ROR) || (m == ASR);
  endfunction
endpackage

// File: rtl/dff_en_srst.sv
// dff_en_srst: W-bit D register with clock enable and synchronous reset.
//   clk  rising-edge clock
//   rst  sync reset, active-high; loads RST_VAL and overrides en
//   en   load d when high, hold otherwise
//   d    next-state data
//   q    registered value
module dff_en_srst #(
  parameter int         W       = 8,
  parameter logic [W-1:0] RST_VAL = '0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);
  always_ff @(posedge clk) begin
    if (rst)     q <= RST_VAL;
    else if (en) q <= d;
  end
endmodule

// File: rtl/univ_shift_reg.sv
// univ_shift_reg: WIDTH-bit universal shift register.
// Supported ops: hold, shift, rotate, arithmetic shift right, parallel load and clear.
// Ports:
//   clk, rst        clock and sync active-high reset (q <= RESET_VAL)
//   en              clock enable; 0 holds everything
//   mode            usr_mode_e op select, sampled on enabled edges
//   sin_l / sin_r   serial inputs for SHL / SHR
//   pdata           parallel load data
//   q               register contents
//   sout_l / sout_r q[WIDTH-1] / q[0], the bit about to leave on SHL / SHR
//   shift_cnt       saturating count of shift-type ops (USR_SHIFT_CNT_EN only)
// Build option: define USR_SHIFT_CNT_EN to add the shift_cnt port and counter.
module univ_shift_reg
  import usr_pkg::*;
#(
  parameter int             WIDTH     = 8,
  parameter logic [WIDTH-1:0] RESET_VAL = '0,
  parameter int             CNT_W     = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [2:0]       mode,
  input  logic             sin_l,
  input  logic             sin_r,
  input  logic [WIDTH-1:0] pdata,
  output logic [WIDTH-1:0] q,
  output logic             sout_l,
  output logic             sout_r
`ifdef USR_SHIFT_CNT_EN
  ,output logic [CNT_W-1:0] shift_cnt
`endif
);
  usr_mode_e        op;
  logic [WIDTH-1:0] q_nxt;

  assign op = usr_mode_e'(mode);

  always_comb begin
    q_nxt = q;
    case (op)
      HOLD: q_nxt = q;
      SHL:  q_nxt = {q[WIDTH-2:0], sin_l};
      SHR:  q_nxt = {sin_r, q[WIDTH-1:1]};
      ROL:  q_nxt = {q[WIDTH-2:0], q[WIDTH-1]};
      ROR:  q_nxt = {q[0], q[WIDTH-1:1]};
      ASR:  q_nxt = {q[WIDTH-1], q[WIDTH-1:1]};
      LOAD: q_nxt = pdata;
      CLR:  q_nxt = '0;   // CLR always clears to zero, even when RESET_VAL is nonzero
      default: q_nxt = q;
    endcase
  end

  dff_en_srst #(.W(WIDTH), .RST_VAL(RESET_VAL)) u_q (
    .clk (clk),
    .rst (rst),
    .en  (en),
    .d   (q_nxt),
    .q   (q)
  );

  assign sout_l = q[WIDTH-1];
  assign sout_r = q[0];

`ifdef USR_SHIFT_CNT_EN
  logic [CNT_W-1:0] cnt_nxt;

  always_comb begin
    cnt_nxt = shift_cnt;
    if (op == LOAD || op == CLR)
      cnt_nxt = '0;
    else if (is_shift_op(op) && (shift_cnt != {CNT_W{1'b1}}))
      cnt_nxt = shift_cnt + 1'b1;   // saturating increment
  end

  dff_en_srst #(.W(CNT_W), .RST_VAL('0)) u_cnt (
    .clk (clk),
    .rst (rst),
    .en  (en),
    .d   (cnt_nxt),
    .q   (shift_cnt)
  );
`endif
endmodule
